avg_sequencer: RTL and testbench
================================

Name: avg_sequencer

Overview:
Fetch/execute controller for the AVG vector processor.
- Fetches 16-bit words from vector memory and assembles the 32-bit instruction word for the instruction decoder (avg_decode).
- Consumes the decoded control bits and advances the byte-addressed PC.
- Handles JMP, JSR and RTS through a return stack.
- Hands vector commands to the vector generator with a valid/ready handshake.
- Pulses register writes for the Z/colour and scale registers.
- Stops on HALT until the CPU issues the next go.

Parameters:
STACK_DEPTH, 4, return-stack entries (power of 2).
MEM_AW, 15, word address width (byte PC = MEM_AW+1 bits, 16).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
go  in  1  one-cycle start pulse from CPU (VGGO)
mem_rd  out  1  memory read request, held until mem_valid
mem_addr  out  MEM_AW  word address = pc[15:1] (+1 for second word)
mem_data  in  16  read data
mem_valid  in  1  read data valid, any latency ≥1
inst  out  32  to decoder; [31:16] first word, [15:0] second word
d_jmp, d_jsr, d_ret, d_halt, d_vector, d_center, d_zWrEn, d_scalWrEn  in  1 each  decoder outputs
d_jumpAddr  in  16  decoder jump byte address
d_pcOffset  in  3  decoder PC increment in bytes
d_instLength  in  3  decoder execute-cycle count
vec_valid  out  1  vector command valid
vec_ready  in  1  vector generator accepts
z_wr, scal_wr, cntr  out  1  one-cycle write/center strobes
halted  out  1  processor stopped
err  out  1  sticky stack overflow/underflow
pc  out  16  current byte PC

Behaviour:
- Reset, applied on any cycle and in any state:
  - state goes to HALTED; pc=0; stack pointer=0; inst=0.
  - halted=1, err=0, mem_rd=0, vec_valid=0, all strobes 0.
- go in HALTED:
  - pc←0, err←0, sp←0, halted←0, go to FETCH0.
  - go in any other state is ignored.
- FETCH0:
  - mem_rd=1, mem_addr=pc[15:1].
  - On mem_valid, inst[31:16]←mem_data.
  - If mem_data[7:5]==OP_VCTR, go to FETCH1; else go to DECODE with inst[15:0]←0.
- FETCH1:
  - mem_rd=1, mem_addr=pc[15:1]+1, wrapping modulo 2^MEM_AW.
  - On mem_valid, inst[15:0]←mem_data, go to DECODE.
- DECODE (1 cycle, decoder inputs sampled), priority in this order:
  - d_halt: halted←1, go to HALTED; pc is not advanced.
  - d_jsr:
    - sp==STACK_DEPTH: err←1, halt.
    - Otherwise push pc+d_pcOffset, sp++, pc←d_jumpAddr.
  - d_jmp (without jsr): pc←d_jumpAddr.
  - d_ret:
    - sp==0: err←1, halt.
    - Otherwise sp--, pc←popped value.
  - All other opcodes: pc←pc+d_pcOffset (16-bit wrap).
  - d_zWrEn→z_wr, d_scalWrEn→scal_wr, d_center→cntr: each asserted for exactly this one cycle.
  - Load the execute counter with d_instLength; next state is VWAIT if d_vector, else EXEC.
- VWAIT:
  - vec_valid=1 until the cycle vec_ready=1.
  - inst is held stable while vec_valid=1.
  - After the handshake, go to EXEC.
- EXEC:
  - Counter decrements each cycle; go to FETCH0 when it reaches 0.
  - A loaded 0 exits after 1 cycle.
  - Models AVG instruction timing.
- Stack: push and pop never happen in the same cycle. A popped entry is not cleared.
- Latency: a non-vector op with instLength=N takes 2 (FETCH0 with single-cycle memory) + 1 (DECODE) + max(N,1) cycles.

Decomposition:
- avg_pkg holds: the state enum (HALTED, FETCH0, FETCH1, DECODE, VWAIT, EXEC), the OP_* opcode constants shared with the decoder, and the PC width constant.
- Sub-module avg_ret_stack: push/pop, data, full/empty flags, synchronous active-low reset.

Test Plan:
1. Reset, then go; memory holds CNTR at 0x0000 and HALT at 0x0002 → cntr pulses once; pc ends at 0x0002; halted=1; err=0.
2. VCTR at 0x0000 with vec_ready held low 5 cycles → two reads at word addresses 0 and 1; vec_valid held 5+1 cycles with inst stable; next fetch at pc=0x0004.
3. JSR to 0x0100 at 0x0000; RTS at 0x0100; HALT at 0x0002 → fetch order is 0x0000, 0x0100, 0x0002; sp returns to 0.
4. Five nested JSRs with STACK_DEPTH=4 → err=1 and halted=1 on the fifth; an RTS with an empty stack also sets err.
5. mem_valid delayed 3 cycles, with rst_n asserted mid-FETCH1 → mem_rd drops the next cycle; pc=0; halted=1.
6. STAT then SCAL, with go pulsed during EXEC → z_wr and scal_wr each pulse once; go is ignored; sequence proceeds to the following fetch.

Source files
------------

// File: rtl/avg_pkg.sv
// Shared definitions for the AVG vector processor sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package avg_pkg;

  // Byte program counter width.
  localparam int PC_W = 16;

  // Sequencer states.
  typedef enum logic [2:0] {
    HALTED = 3'd0,
    FETCH0 = 3'd1,
    FETCH1 = 3'd2,
    DECODE = 3'd3,
    VWAIT  = 3'd4,
    EXEC   = 3'd5
  } state_t;

  // Opcodes in bits [7:5] of the first instruction word, shared with avg_decode.
  localparam logic [2:0] OP_VCTR = 3'd0;
  localparam logic [2:0] OP_HALT = 3'd1;
  localparam logic [2:0] OP_SVEC = 3'd2;
  localparam logic [2:0] OP_STAT = 3'd3;
  localparam logic [2:0] OP_CNTR = 3'd4;
  localparam logic [2:0] OP_JSR  = 3'd5;
  localparam logic [2:0] OP_RTS  = 3'd6;
  localparam logic [2:0] OP_JMP  = 3'd7;

endpackage

// File: rtl/avg_ret_stack.sv
// Return-address stack for JSR/RTS.
// Latency: push/pop take effect at the next clock; rdata shows the top entry combinationally.
// Backpressure: push while full and pop while empty are ignored; the caller checks full/empty.
// Ports: clk, rst_n (sync, active low), clr (sync flush), push/wdata, pop/rdata, full, empty.
module avg_ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  count;
  logic [AW:0]  top_cnt;

  // Entry below the count is the top; popped entries are left in place.
  assign top_cnt = count - 1'b1;
  assign rdata   = mem[top_cnt[AW-1:0]];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (push && !full) begin
      mem[count[AW-1:0]] <= wdata;
      count              <= count + 1'b1;
    end else if (pop && !empty) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/avg_sequencer.sv
// Fetch/execute controller for the AVG vector processor: fetches, hands inst to the decoder, steps the PC.
// Latency: non-vector op = 2 fetch cycles (1-cycle memory) + 1 decode + max(instLength,1) exec cycles.
// Backpressure: mem_rd held until mem_valid; vec_valid held (inst stable) until vec_ready.
// Ports: go starts from HALTED; mem_* word fetch; inst/d_* decoder loop; vec_valid/vec_ready vector
// handoff; z_wr/scal_wr/cntr one-cycle strobes; halted, sticky err, byte pc.
module avg_sequencer
  import avg_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int MEM_AW      = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  input  logic              mem_valid,
  output logic [31:0]       inst,
  input  logic              d_jmp,
  input  logic              d_jsr,
  input  logic              d_ret,
  input  logic              d_halt,
  input  logic              d_vector,
  input  logic              d_center,
  input  logic              d_zWrEn,
  input  logic              d_scalWrEn,
  input  logic [15:0]       d_jumpAddr,
  input  logic [2:0]        d_pcOffset,
  input  logic [2:0]        d_instLength,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic              z_wr,
  output logic              scal_wr,
  output logic              cntr,
  output logic              halted,
  output logic              err,
  output logic [PC_W-1:0]   pc
);

  state_t             state, state_nx;
  logic [PC_W-1:0]    pc_q, pc_nx;
  logic [31:0]        inst_q, inst_nx;
  logic [2:0]         cnt_q, cnt_nx;
  logic               err_q, err_nx;

  logic               stk_push, stk_pop, stk_clr;
  logic               stk_full, stk_empty;
  logic [PC_W-1:0]    stk_rdata;
  logic [PC_W-1:0]    pc_next_seq;
  logic [MEM_AW-1:0]  word_addr;

  assign pc_next_seq = pc_q + {13'd0, d_pcOffset};
  assign word_addr   = pc_q[MEM_AW:1];

  assign pc   = pc_q;
  assign inst = inst_q;
  assign err  = err_q;

  avg_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stk_clr),
    .push  (stk_push),
    .wdata (pc_next_seq),
    .pop   (stk_pop),
    .rdata (stk_rdata),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= HALTED;
      pc_q   <= '0;
      inst_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      pc_q   <= pc_nx;
      inst_q <= inst_nx;
      cnt_q  <= cnt_nx;
      err_q  <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc_q;
    inst_nx   = inst_q;
    cnt_nx    = cnt_q;
    err_nx    = err_q;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clr   = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = word_addr;
    vec_valid = 1'b0;
    z_wr      = 1'b0;
    scal_wr   = 1'b0;
    cntr      = 1'b0;
    halted    = 1'b0;

    unique case (state)
      HALTED: begin
        halted = 1'b1;
        if (go) begin
          pc_nx    = '0;
          err_nx   = 1'b0;
          stk_clr  = 1'b1;
          state_nx = FETCH0;
        end
      end

      FETCH0: begin
        mem_rd = 1'b1;
        if (mem_valid) begin
          inst_nx[31:16] = mem_data;
          // Only long vectors carry a second word; short ops decode with a zero low half.
          if (mem_data[7:5] == OP_VCTR) begin
            state_nx = FETCH1;
          end else begin
            inst_nx[15:0] = '0;
            state_nx      = DECODE;
          end
        end
      end

      FETCH1: begin
        mem_rd   = 1'b1;
        mem_addr = word_addr + 1'b1;
        if (mem_valid) begin
          inst_nx[15:0] = mem_data;
          state_nx      = DECODE;
        end
      end

      DECODE: begin
        z_wr     = d_zWrEn;
        scal_wr  = d_scalWrEn;
        cntr     = d_center;
        cnt_nx   = d_instLength;
        state_nx = d_vector ? VWAIT : EXEC;
        if (d_halt) begin
          state_nx = HALTED;
        end else if (d_jsr) begin
          if (stk_full) begin
            err_nx   = 1'b1;
            state_nx = HALTED;
          end else begin
            stk_push = 1'b1;
            pc_nx    = d_jumpAddr;
          end
        end else if (d_jmp) begin
          pc_nx = d_jumpAddr;
        end else if (d_ret) begin
          if (stk_empty) begin
            err_nx   = 1'b1;
            state_nx = HALTED;
          end else begin
            stk_pop = 1'b1;
            pc_nx   = stk_rdata;
          end
        end else begin
          pc_nx = pc_next_seq;
        end
      end

      VWAIT: begin
        vec_valid = 1'b1;
        if (vec_ready) begin
          state_nx = EXEC;
        end
      end

      EXEC: begin
        // A loaded 0 behaves like 1 so every op spends at least one exec cycle.
        cnt_nx = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          cnt_nx   = '0;
          state_nx = FETCH0;
        end
      end

      default: begin
        state_nx = HALTED;
      end
    endcase
  end

endmodule

// File: tb/tb_avg_sequencer.sv
// Bench for avg_sequencer: memory model, tiny decoder, vector sink, event scoreboard.
// Latency: memory returns data 'lat' cycles after the read request appears.
// Backpressure: vec_ready withheld for 'vhold' cycles of vec_valid.
module tb_avg_sequencer;
  import avg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic        mem_rd;
  logic [14:0] mem_addr;
  logic [15:0] mem_data = 16'h0000;
  logic        mem_valid = 1'b0;
  logic [31:0] inst;
  logic        d_jmp, d_jsr, d_ret, d_halt, d_vector, d_center, d_zWrEn, d_scalWrEn;
  logic [15:0] d_jumpAddr;
  logic [2:0]  d_pcOffset, d_instLength;
  logic        vec_valid;
  logic        vec_ready = 1'b0;
  logic        z_wr, scal_wr, cntr, halted, err;
  logic [15:0] pc;

  always #5 clk = ~clk;

  avg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .go(go),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid),
    .inst(inst),
    .d_jmp(d_jmp), .d_jsr(d_jsr), .d_ret(d_ret), .d_halt(d_halt), .d_vector(d_vector),
    .d_center(d_center), .d_zWrEn(d_zWrEn), .d_scalWrEn(d_scalWrEn),
    .d_jumpAddr(d_jumpAddr), .d_pcOffset(d_pcOffset), .d_instLength(d_instLength),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .z_wr(z_wr), .scal_wr(scal_wr), .cntr(cntr), .halted(halted), .err(err), .pc(pc)
  );

  // Bench instruction format (first word): [15:8] jump target high byte, [7:5] opcode,
  // [4] SCAL select for op 3, [2:0] exec length.
  logic [2:0] op;
  assign op           = inst[23:21];
  assign d_vector     = (op == OP_VCTR);
  assign d_halt       = (op == OP_HALT);
  assign d_jsr        = (op == OP_JSR);
  assign d_jmp        = (op == OP_JMP);
  assign d_ret        = (op == OP_RTS);
  assign d_center     = (op == OP_CNTR);
  assign d_zWrEn      = (op == OP_STAT) && !inst[20];
  assign d_scalWrEn   = (op == OP_STAT) && inst[20];
  assign d_jumpAddr   = {inst[31:24], 8'h00};
  assign d_pcOffset   = (op == OP_VCTR) ? 3'd4 : 3'd2;
  assign d_instLength = inst[18:16];

  function automatic logic [15:0] mk(input logic [2:0] o, input logic [7:0] hi,
                                     input logic [2:0] len, input logic b4);
    return {hi, o, b4, 1'b0, len};
  endfunction

  localparam logic [31:0] EV_CNTR = 32'h0200_0000;
  localparam logic [31:0] EV_ZWR  = 32'h0300_0000;
  localparam logic [31:0] EV_SCAL = 32'h0400_0000;

  function automatic logic [31:0] ev_fetch(input logic [14:0] a);
    return {8'd1, 8'd0, 1'b0, a};
  endfunction

  function automatic logic [31:0] ev_vec(input int n);
    return {8'd5, 8'd0, 16'(n)};
  endfunction

  logic [15:0] mem [0:32767];
  int          lat   = 1;
  int          pend  = 0;
  int          vhold = 0;
  int          vcnt  = 0;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] expq[$];
  logic [31:0] exp_vec_inst = 32'h0;
  int          mon_vcnt = 0;

  // Memory: data valid for one cycle, 'lat' cycles after the request starts.
  always @(negedge clk) begin
    if (mem_valid) begin
      mem_valid = 1'b0;
      pend      = 0;
    end
    if (mem_rd) begin
      if (pend == lat) begin
        mem_valid = 1'b1;
        mem_data  = mem[mem_addr];
        pend      = 0;
      end else begin
        pend++;
      end
    end else begin
      pend = 0;
    end
  end

  // Vector sink: accept on the (vhold+1)-th cycle of vec_valid.
  always @(negedge clk) begin
    if (vec_valid) begin
      vcnt++;
      vec_ready = (vcnt > vhold);
    end else begin
      vcnt      = 0;
      vec_ready = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  task automatic got_event(input logic [31:0] ev);
    logic [31:0] e;
    if (expq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got %h want none", ev);
    end else begin
      e = expq.pop_front();
      check("event", ev, e);
    end
  endtask

  // Monitor: samples between edges and scores every observable output event.
  always begin
    @(negedge clk);
    #2;
    if (mem_rd && mem_valid) got_event(ev_fetch(mem_addr));
    if (cntr)                got_event(EV_CNTR);
    if (z_wr)                got_event(EV_ZWR);
    if (scal_wr)             got_event(EV_SCAL);
    if (vec_valid) begin
      mon_vcnt++;
      check("vec_inst_stable", inst, exp_vec_inst);
      if (vec_ready) begin
        got_event(ev_vec(mon_vcnt));
        mon_vcnt = 0;
      end
    end else begin
      mon_vcnt = 0;
    end
  end

  task automatic start_go();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_halt(output int cycles);
    cycles = 0;
    while (!halted && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    if (!halted) timeout_fail("halt_timeout");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n;
    rst_n = 1'b0;
    go    = 1'b0;
    for (int i = 0; i < 32768; i++) mem[i] = mk(OP_HALT, 8'h00, 3'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_vec_valid", 32'(vec_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: CNTR (len 3) then HALT.
    mem[0] = mk(OP_CNTR, 8'h00, 3'd3, 1'b0);
    mem[1] = mk(OP_HALT, 8'h00, 3'd0, 1'b0);
    expq.push_back(ev_fetch(15'd0));
    expq.push_back(EV_CNTR);
    expq.push_back(ev_fetch(15'd1));
    start_go();
    wait_halt(cyc);
    check("t1_cycles", 32'(cyc), 32'd9);
    check("t1_pc", 32'(pc), 32'h0002);
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_drained", 32'(expq.size()), 32'd0);

    // 2: VCTR with vec_ready held off 5 cycles.
    mem[0] = mk(OP_VCTR, 8'h00, 3'd1, 1'b0);
    mem[1] = 16'hBEEF;
    mem[2] = mk(OP_HALT, 8'h00, 3'd0, 1'b0);
    exp_vec_inst = {mk(OP_VCTR, 8'h00, 3'd1, 1'b0), 16'hBEEF};
    vhold = 5;
    expq.push_back(ev_fetch(15'd0));
    expq.push_back(ev_fetch(15'd1));
    expq.push_back(ev_vec(6));
    expq.push_back(ev_fetch(15'd2));
    start_go();
    wait_halt(cyc);
    vhold = 0;
    check("t2_pc", 32'(pc), 32'h0004);
    check("t2_drained", 32'(expq.size()), 32'd0);

    // 3: JSR 0x0100, RTS there, HALT at 0x0002.
    mem[0]     = mk(OP_JSR, 8'h01, 3'd0, 1'b0);
    mem[1]     = mk(OP_HALT, 8'h00, 3'd0, 1'b0);
    mem[15'h80] = mk(OP_RTS, 8'h00, 3'd0, 1'b0);
    expq.push_back(ev_fetch(15'd0));
    expq.push_back(ev_fetch(15'h80));
    expq.push_back(ev_fetch(15'd1));
    start_go();
    wait_halt(cyc);
    check("t3_pc", 32'(pc), 32'h0002);
    check("t3_sp", 32'(dut.u_stack.count), 32'd0);
    check("t3_err", 32'(err), 32'd0);
    check("t3_drained", 32'(expq.size()), 32'd0);

    // 4a: five nested JSRs overflow a 4-deep stack.
    for (int k = 0; k < 5; k++) begin
      mem[k * 128] = mk(OP_JSR, 8'(k + 1), 3'd0, 1'b0);
      expq.push_back(ev_fetch(15'(k * 128)));
    end
    start_go();
    wait_halt(cyc);
    check("t4_err", 32'(err), 32'd1);
    check("t4_halted", 32'(halted), 32'd1);
    check("t4_pc", 32'(pc), 32'h0400);
    check("t4_drained", 32'(expq.size()), 32'd0);

    // 4b: RTS on an empty stack; go clears the old error first.
    mem[0] = mk(OP_RTS, 8'h00, 3'd0, 1'b0);
    expq.push_back(ev_fetch(15'd0));
    start_go();
    check("t4b_err_cleared", 32'(err), 32'd0);
    wait_halt(cyc);
    check("t4b_err", 32'(err), 32'd1);
    check("t4b_pc", 32'(pc), 32'h0000);
    check("t4b_drained", 32'(expq.size()), 32'd0);

    // 5: slow memory, reset while the second word is outstanding.
    lat    = 3;
    mem[0] = mk(OP_VCTR, 8'h00, 3'd1, 1'b0);
    mem[1] = 16'h1234;
    expq.push_back(ev_fetch(15'd0));
    start_go();
    n = 0;
    while (!(mem_rd && mem_addr == 15'd1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(mem_rd && mem_addr == 15'd1)) timeout_fail("t5_fetch1_timeout");
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_mem_rd", 32'(mem_rd), 32'd0);
    check("t5_pc", 32'(pc), 32'h0000);
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_inst", inst, 32'd0);
    rst_n = 1'b1;
    lat   = 1;
    @(negedge clk);
    check("t5_drained", 32'(expq.size()), 32'd0);

    // 6: STAT then SCAL, go pulsed during EXEC must be ignored.
    mem[0] = mk(OP_STAT, 8'h00, 3'd4, 1'b0);
    mem[1] = mk(OP_STAT, 8'h00, 3'd2, 1'b1);
    mem[2] = mk(OP_HALT, 8'h00, 3'd0, 1'b0);
    expq.push_back(ev_fetch(15'd0));
    expq.push_back(EV_ZWR);
    expq.push_back(ev_fetch(15'd1));
    expq.push_back(EV_SCAL);
    expq.push_back(ev_fetch(15'd2));
    start_go();
    n = 0;
    while (!z_wr && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!z_wr) timeout_fail("t6_zwr_timeout");
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_halt(cyc);
    check("t6_pc", 32'(pc), 32'h0004);
    check("t6_err", 32'(err), 32'd0);
    check("t6_drained", 32'(expq.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
